// File: rtl/xband_rx_align_if.sv
// Bus bundle for the comma aligner: raw deserializer side in, aligned side out.
interface xband_rx_align_if;
  logic       bitswap;
  logic [9:0] raw_10bit;
  logic       raw_val;
  logic [9:0] data_in_10bit;
  logic       data_in_val;
  logic       locked;
  logic [3:0] align_offset;
  logic       comma_det;
  logic [7:0] realign_cnt;

  // Deserializer / stimulus side
  modport master (
    output bitswap, raw_10bit, raw_val,
    input  data_in_10bit, data_in_val, locked, align_offset, comma_det, realign_cnt
  );

  // Aligner side
  modport slave (
    input  bitswap, raw_10bit, raw_val,
    output data_in_10bit, data_in_val, locked, align_offset, comma_det, realign_cnt
  );
endinterface

// File: rtl/xband_rx_align.sv
// K28.5 comma aligner: searches a 2-word window for a comma at any of 10 bit
// offsets, qualifies it with a hunt/verify/locked FSM, and outputs aligned words.
module xband_rx_align #(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4,
  parameter logic [9:0]  COMMA_N  = 10'b0011111010,
  parameter logic [9:0]  COMMA_P  = 10'b1100000101
) (
  input logic             rx_clk,
  input logic             rx_rst,
  xband_rx_align_if.slave bus
);

  localparam logic [1:0] StHunt   = 2'd0;
  localparam logic [1:0] StVerify = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  localparam logic [3:0] LockCnt = LOCK_CNT[3:0];
  localparam logic [3:0] LossCnt = LOSS_CNT[3:0];

  logic [1:0]  state_q, state_d;
  logic [9:0]  prev_q;
  logic [3:0]  offset_q, offset_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  miss_q, miss_d;
  logic [7:0]  realign_q, realign_d;
  logic [9:0]  data_q;
  logic        data_val_q;
  logic        locked_q;
  logic        comma_q;

  logic [9:0]  s;
  logic [18:0] w;
  logic [9:0]  hit;
  logic        hit_any;
  logic [3:0]  hit_off;
  logic        hit_at_off;
  logic [9:0]  cand_off;

  // Optional bit reversal; offset 9 is the highest window slice, so s[9] only feeds prev.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      s[i] = bus.bitswap ? bus.raw_10bit[9-i] : bus.raw_10bit[i];
    end
  end

  assign w = {s[8:0], prev_q};

  for (genvar k = 0; k < 10; k++) begin : g_cand
    assign hit[k] = (w[k+9:k] == COMMA_N) || (w[k+9:k] == COMMA_P);
  end

  // Lowest-offset hit, plus the hit flag and candidate word at the current offset.
  always_comb begin
    hit_off    = 4'd0;
    hit_at_off = 1'b0;
    cand_off   = 10'd0;
    for (int k = 9; k >= 0; k--) begin
      if (hit[k]) hit_off = 4'(k);
      if (offset_q == 4'(k)) begin
        hit_at_off = hit[k];
        cand_off   = w[k +: 10];
      end
    end
  end

  assign hit_any = |hit;

  // Alignment FSM and counters; everything holds on non-valid cycles.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    match_d   = match_q;
    miss_d    = miss_q;
    realign_d = realign_q;
    if (bus.raw_val && hit_any) begin
      unique case (state_q)
        StHunt: begin
          offset_d = hit_off;
          if (LockCnt == 4'd1) begin
            state_d = StLocked;
            match_d = 4'd0;
          end else begin
            state_d = StVerify;
            match_d = 4'd1;
          end
        end
        StVerify: begin
          if (hit_off == offset_q) begin
            if (match_q + 4'd1 == LockCnt) begin
              state_d = StLocked;
              match_d = 4'd0;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else begin
            offset_d = hit_off;
            match_d  = 4'd1;
          end
        end
        StLocked: begin
          // A hit at the locked offset wins over lower-offset hits.
          if (hit_at_off) begin
            miss_d = 4'd0;
          end else if (miss_q + 4'd1 == LossCnt) begin
            state_d = StHunt;
            miss_d  = 4'd0;
            if (realign_q != 8'hFF) realign_d = realign_q + 8'd1;
          end else begin
            miss_d = miss_q + 4'd1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State, window history and registered outputs; reset wins over raw_val.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q    <= StHunt;
      prev_q     <= 10'd0;
      offset_q   <= 4'd0;
      match_q    <= 4'd0;
      miss_q     <= 4'd0;
      realign_q  <= 8'd0;
      data_q     <= 10'd0;
      data_val_q <= 1'b0;
      locked_q   <= 1'b0;
      comma_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      realign_q  <= realign_d;
      locked_q   <= (state_d == StLocked);
      comma_q    <= bus.raw_val && hit_any;
      data_val_q <= bus.raw_val && (state_q == StLocked);
      if (bus.raw_val) prev_q <= s;
      if (bus.raw_val && (state_q == StLocked)) data_q <= cand_off;
    end
  end

  assign bus.data_in_10bit = data_q;
  assign bus.data_in_val   = data_val_q;
  assign bus.locked        = locked_q;
  assign bus.align_offset  = offset_q;
  assign bus.comma_det     = comma_q;
  assign bus.realign_cnt   = realign_q;

endmodule

// File: tb/tb_xband_rx_align.sv
// Bench for xband_rx_align: directed alignment scenarios with literal expectations,
// then randomized shifted comma streams checked every cycle against a word-level model.
module tb_xband_rx_align;

  localparam int         LockCnt = 3;
  localparam int         LossCnt = 4;
  localparam logic [9:0] CommaN  = 10'b0011111010;
  localparam logic [9:0] CommaP  = 10'b1100000101;

  logic rx_clk = 1'b0;
  logic rx_rst = 1'b1;
  bit   chk_en = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  xband_rx_align_if bus ();

  xband_rx_align #(
    .LOCK_CNT (LockCnt),
    .LOSS_CNT (LossCnt),
    .COMMA_N  (CommaN),
    .COMMA_P  (CommaP)
  ) dut (
    .rx_clk (rx_clk),
    .rx_rst (rx_rst),
    .bus    (bus)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] rev(input logic [9:0] x);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = x[9-i];
    return r;
  endfunction

  // ---------------- word-level reference model ----------------
  int         m_state;    // 0 hunt, 1 verify, 2 locked
  logic [9:0] m_prev, m_data;
  int         m_off, m_match, m_miss, m_realign;
  bit         m_val, m_comma;

  task automatic model_step();
    logic [19:0] win;
    logic [9:0]  sw, c;
    int          h;
    bit          at_off;
    if (rx_rst) begin
      m_state = 0; m_prev = '0; m_data = '0; m_off = 0; m_match = 0; m_miss = 0;
      m_realign = 0; m_val = 0; m_comma = 0;
    end else if (bus.raw_val) begin
      sw  = bus.bitswap ? rev(bus.raw_10bit) : bus.raw_10bit;
      win = {sw, m_prev};
      h = -1; at_off = 0;
      for (int k = 9; k >= 0; k--) begin
        c = win[k +: 10];
        if (c == CommaN || c == CommaP) begin
          h = k;
          if (k == m_off) at_off = 1;
        end
      end
      m_comma = (h >= 0);
      m_val   = (m_state == 2);
      if (m_val) m_data = win[m_off +: 10];
      if (h >= 0) begin
        if (m_state == 0) begin
          m_off = h;
          if (LockCnt == 1) begin m_state = 2; m_match = 0; end
          else begin m_state = 1; m_match = 1; end
        end else if (m_state == 1) begin
          if (h == m_off) begin
            m_match++;
            if (m_match == LockCnt) begin m_state = 2; m_match = 0; end
          end else begin
            m_off = h; m_match = 1;
          end
        end else begin
          if (at_off) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss == LossCnt) begin
              m_state = 0; m_miss = 0;
              if (m_realign < 255) m_realign++;
            end
          end
        end
      end
      m_prev = sw;
    end else begin
      m_val = 0; m_comma = 0;
    end
  endtask

  // Model update on each edge, DUT compare just after it.
  always @(posedge rx_clk) begin
    model_step();
    #1;
    if (chk_en) begin
      check("cyc_locked",  {31'd0, bus.locked},       {31'd0, m_state == 2});
      check("cyc_offset",  {28'd0, bus.align_offset}, 32'(m_off));
      check("cyc_val",     {31'd0, bus.data_in_val},  {31'd0, m_val});
      check("cyc_data",    {22'd0, bus.data_in_10bit}, {22'd0, m_data});
      check("cyc_comma",   {31'd0, bus.comma_det},    {31'd0, m_comma});
      check("cyc_realign", {24'd0, bus.realign_cnt},  32'(m_realign));
    end
  end

  // ---------------- stimulus ----------------
  logic [9:0] a_prev = '0;

  function automatic logic [9:0] pat(input int n);
    if (n % 4 == 0) return ((n / 4) % 2 == 0) ? CommaN : CommaP;
    return 10'h155;
  endfunction

  task automatic send(input logic [9:0] raw, input bit val, input bit swap);
    @(negedge rx_clk);
    bus.raw_10bit = raw;
    bus.raw_val   = val;
    bus.bitswap   = swap;
    @(posedge rx_clk);
    #2;
  endtask

  // Sends aligned word a shifted up by k bits into the raw stream.
  task automatic send_shifted(input logic [9:0] a, input int k, input bit swap);
    logic [9:0] raw;
    raw = (a << k) | (a_prev >> (10 - k));
    a_prev = a;
    send(swap ? rev(raw) : raw, 1'b1, swap);
  endtask

  task automatic do_reset();
    @(negedge rx_clk);
    rx_rst        = 1'b1;
    bus.raw_val   = 1'b1;       // word in a reset cycle must be discarded
    bus.raw_10bit = CommaN;
    @(posedge rx_clk);
    #2;
    rx_rst      = 1'b0;
    bus.raw_val = 1'b0;
    a_prev      = '0;
  endtask

  // Runs the standard comma stream at shift k and pins the lock timing.
  task automatic lock_scenario(input string tag, input int k, input bit swap);
    for (int n = 0; n < 9; n++) begin
      send_shifted(pat(n), k, swap);
      if (n == 0) check({tag, "_no_comma_w0"}, {31'd0, bus.comma_det}, 32'd0);
      if (n == 1) begin
        check({tag, "_comma_w1"}, {31'd0, bus.comma_det}, 32'd1);
        check({tag, "_offset_w1"}, {28'd0, bus.align_offset}, 32'(k));
      end
    end
    check({tag, "_unlocked_w8"}, {31'd0, bus.locked}, 32'd0);
    send_shifted(pat(9), k, swap);
    check({tag, "_locked_w9"}, {31'd0, bus.locked}, 32'd1);
    check({tag, "_noval_w9"}, {31'd0, bus.data_in_val}, 32'd0);
    send_shifted(pat(10), k, swap);
    check({tag, "_val_w10"}, {31'd0, bus.data_in_val}, 32'd1);
    check({tag, "_data_w10"}, {22'd0, bus.data_in_10bit}, 32'h155);
  endtask

  initial begin
    bit         saw_unlock;
    int         k, len, n;
    bit         swap;
    logic [9:0] a;

    bus.raw_10bit = '0;
    bus.raw_val   = 1'b0;
    bus.bitswap   = 1'b0;
    @(posedge rx_clk);
    #2;
    rx_rst = 1'b0;
    check("rst_locked",  {31'd0, bus.locked}, 32'd0);
    check("rst_val",     {31'd0, bus.data_in_val}, 32'd0);
    check("rst_data",    {22'd0, bus.data_in_10bit}, 32'd0);
    check("rst_realign", {24'd0, bus.realign_cnt}, 32'd0);

    // Aligned stream, then shift to offset 3 while locked.
    lock_scenario("aligned", 0, 1'b0);
    saw_unlock = 0;
    for (n = 11; n < 51; n++) begin
      send_shifted(pat(n), 3, 1'b0);
      if (!bus.locked) saw_unlock = 1;
    end
    check("shift_loss_seen", {31'd0, saw_unlock}, 32'd1);
    check("shift_relock",    {31'd0, bus.locked}, 32'd1);
    check("shift_offset",    {28'd0, bus.align_offset}, 32'd3);
    check("shift_realign",   {24'd0, bus.realign_cnt}, 32'd1);

    // Reset while locked, then relock needs three fresh commas.
    do_reset();
    check("rst2_locked",  {31'd0, bus.locked}, 32'd0);
    check("rst2_offset",  {28'd0, bus.align_offset}, 32'd0);
    check("rst2_comma",   {31'd0, bus.comma_det}, 32'd0);
    check("rst2_realign", {24'd0, bus.realign_cnt}, 32'd0);
    lock_scenario("relock", 0, 1'b0);

    do_reset();
    lock_scenario("shift7", 7, 1'b0);
    do_reset();
    lock_scenario("bitswap", 0, 1'b1);

    // raw_val toggling: idle cycles carry garbage that must be ignored.
    do_reset();
    for (n = 0; n < 10; n++) begin
      send_shifted(pat(n), 0, 1'b0);
      send(10'($urandom), 1'b0, 1'b0);
      check("toggle_idle_noval", {31'd0, bus.data_in_val}, 32'd0);
    end
    check("toggle_locked", {31'd0, bus.locked}, 32'd1);

    // Randomized shifted streams with commas, idles, bitswap and rare resets.
    for (int seg = 0; seg < 30; seg++) begin
      k    = $urandom_range(0, 9);
      swap = $urandom_range(0, 1);
      len  = $urandom_range(20, 60);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        if ($urandom_range(0, 3) == 0) begin
          send(10'($urandom), 1'b0, swap);
        end else begin
          if ($urandom_range(0, 2) == 0) a = $urandom_range(0, 1) ? CommaN : CommaP;
          else a = 10'($urandom);
          send_shifted(a, k, swap);
        end
      end
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
